// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between NUM_REQ byte producers, the arbiter and the UART TX FIFO write port.
// The producer/FIFO side is the master; the arbiter is the slave.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // valid/ready: a byte of requester i transfers on a rising edge where
  // req_valid[i] & req_ready[i]; the same edge writes it into the FIFO
  // (fifo_wr_en). A requester keeps valid/data/last stable until accepted.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [IDX_W-1:0]              grant_id;
  logic                          busy;
  logic [1:0]                    dbg_state;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, dbg_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among NUM_REQ byte producers.
// A grant is held for a packet (up to MAX_BURST beats); one IDLE cycle separates bursts.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             busy_q;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic             in_xfer;
  logic [NUM_REQ-1:0] gsel;
  logic             g_valid;
  logic             g_last;
  logic             beat;
  logic             burst_end;
  logic [DATA_WIDTH-1:0] g_data;

  // Scan rr_ptr+1, rr_ptr+2, ... so the last released requester comes last.
  always_comb begin : arb_scan
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign in_xfer = (state_q == XFER);

  always_comb begin
    gsel   = '0;
    g_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (in_xfer && (grant_q == IDX_W'(k))) begin
        gsel[k] = 1'b1;
        g_data  = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign g_valid   = |(bus.req_valid & gsel);
  assign g_last    = |(bus.req_last & gsel);
  assign beat      = g_valid & ~bus.fifo_full;
  assign burst_end = g_last | (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  // Ready is offered to the granted requester whenever the FIFO has room,
  // independent of its valid; the transfer itself still needs valid.
  assign bus.req_ready    = bus.fifo_full ? '0 : gsel;
  assign bus.fifo_wr_en   = beat;
  assign bus.fifo_wr_data = g_data;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = busy_q;
  assign bus.dbg_state    = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q    <= winner;
            beat_cnt_q <= '0;
            state_q    <= XFER;
            busy_q     <= 1'b1;
          end
        end
        XFER: begin
          if (!g_valid) begin
            // Requester abandoned its packet: give the port up without writing.
            rr_ptr_q   <= grant_q;
            beat_cnt_q <= '0;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
          end else if (!bus.fifo_full) begin
            if (burst_end) begin
              rr_ptr_q   <= grant_q;
              beat_cnt_q <= '0;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          beat_cnt_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, an expected-write
// queue filled by the stimulus, and a negedge monitor that checks every FIFO write.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int MB      = 16;
  localparam int IDX_W   = 2;
  localparam int EW      = IDX_W + DW;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW:0]        src_q [NUM_REQ][$];
  logic [EW-1:0]      exp_q [$];
  logic [NUM_REQ-1:0] drop_mask = '0;
  logic [NUM_REQ-1:0] acc = '0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- driver ----------------
  function automatic void present();
    logic [NUM_REQ-1:0]    v;
    logic [NUM_REQ-1:0]    l;
    logic [NUM_REQ*DW-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0 && !drop_mask[i]) begin
        v[i]            = 1'b1;
        l[i]            = src_q[i][0][DW];
        d[i*DW +: DW]   = src_q[i][0][DW-1:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endfunction

  task automatic load(input int r, input logic [DW-1:0] first, input int n, input bit last_at_end);
    logic [DW:0] item;
    for (int k = 0; k < n; k++) begin
      item = {(last_at_end && (k == n - 1)), first + DW'(k)};
      src_q[r].push_back(item);
    end
  endtask

  task automatic push_exp(input int r, input logic [DW-1:0] first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({IDX_W'(r), first + DW'(k)});
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    drop_mask = '0;
  endtask

  // Sources pop the byte that was accepted at this edge, then show the next one.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    present();
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    acc = bus.req_valid & bus.req_ready;
    if (bus.fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got grant %0d data 0x%02h, required no write (t=%0t)",
                 bus.grant_id, bus.fifo_wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_beat {grant,data}", {bus.grant_id, bus.fifo_wr_data}, e);
      end
      check("wr_while_full", bus.fifo_full, 1'b0);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk_all_zero(input string n);
    check({n, "_wr_en"}, bus.fifo_wr_en, 1'b0);
    check({n, "_wr_data"}, bus.fifo_wr_data, '0);
    check({n, "_ready"}, bus.req_ready, '0);
    check({n, "_busy"}, bus.busy, 1'b0);
    check({n, "_grant"}, bus.grant_id, '0);
  endtask

  task automatic wait_writes(input string n, input int target, input int max_cyc);
    int seen;
    int k;
    seen = 0;
    k    = 0;
    while (seen < target && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (bus.fifo_wr_en === 1'b1) seen++;
    end
    check({n, "_writes_seen"}, seen, target);
  endtask

  task automatic drain(input string n, input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check({n, "_exp_left"}, exp_q.size(), 0);
    check({n, "_busy_end"}, bus.busy, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    flush_sources();
    present();
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.fifo_full = 1'b0;
    flush_sources();
    present();

    // Reset held, then first cycle after release
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("rst_hold");
    check("rst_state", bus.dbg_state, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_first_cycle");

    // T1: req0 sends 41,42,43 with 1-cycle arbitration latency
    @(posedge clk); #2;
    load(0, 8'h41, 3, 1'b1);
    push_exp(0, 8'h41, 3);
    present();
    @(negedge clk);
    check("t1_arb_wr_en", bus.fifo_wr_en, 1'b0);
    check("t1_arb_busy", bus.busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t1_wr_en", bus.fifo_wr_en, 1'b1);
      check("t1_grant", bus.grant_id, 2'd0);
    end
    @(negedge clk);
    check("t1_end_busy", bus.busy, 1'b0);
    check("t1_end_wr_en", bus.fifo_wr_en, 1'b0);
    drain("t1", 20);

    // T2: all four valid, single-byte packets -> 0,1,2,3,0,1,2,3, write every 2 cycles
    apply_reset();
    @(posedge clk); #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      load(i, DW'(i * 16), 1, 1'b1);
      load(i, DW'(i * 16 + 1), 1, 1'b1);
    end
    for (int i = 0; i < NUM_REQ; i++) push_exp(i, DW'(i * 16), 1);
    for (int i = 0; i < NUM_REQ; i++) push_exp(i, DW'(i * 16 + 1), 1);
    present();
    @(negedge clk);
    check("t2_arb_wr_en", bus.fifo_wr_en, 1'b0);
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      check("t2_wr_en", bus.fifo_wr_en, 1'b1);
      check("t2_grant", bus.grant_id, w % 4);
      @(negedge clk);
      check("t2_dead_cycle", bus.fifo_wr_en, 1'b0);
    end
    drain("t2", 20);

    // T3: req2 streams 20 bytes (no last), req3 one byte; MAX_BURST splits req2
    @(posedge clk); #2;
    load(2, 8'hA0, 20, 1'b0);
    load(3, 8'h77, 1, 1'b1);
    push_exp(2, 8'hA0, 16);
    push_exp(3, 8'h77, 1);
    push_exp(2, 8'hB0, 4);
    present();
    drain("t3", 100);

    // T4: FIFO full for 5 cycles after 2nd beat of a 4-byte packet from req1
    @(posedge clk); #2;
    load(1, 8'h51, 4, 1'b1);
    push_exp(1, 8'h51, 4);
    present();
    wait_writes("t4_pre", 2, 20);
    @(posedge clk); #2;
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_stall_wr_en", bus.fifo_wr_en, 1'b0);
      check("t4_stall_ready", bus.req_ready, '0);
      check("t4_stall_grant", bus.grant_id, 2'd1);
      check("t4_stall_busy", bus.busy, 1'b1);
      check("t4_stall_data", bus.fifo_wr_data, 8'h53);
    end
    @(posedge clk); #2;
    bus.fifo_full = 1'b0;
    drain("t4", 20);

    // T5: reset during XFER after two beats; then req0 wins over req1
    @(posedge clk); #2;
    load(0, 8'h61, 4, 1'b1);
    push_exp(0, 8'h61, 2);
    present();
    wait_writes("t5_pre", 2, 20);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("t5_rst_wr_en", bus.fifo_wr_en, 1'b0);
    check("t5_rst_ready", bus.req_ready, '0);
    check("t5_rst_busy", bus.busy, 1'b0);
    flush_sources();
    load(0, 8'h71, 1, 1'b1);
    load(1, 8'h81, 1, 1'b1);
    push_exp(0, 8'h71, 1);
    push_exp(1, 8'h81, 1);
    present();
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("t5_first_cycle");
    drain("t5", 20);

    // T6: granted req1 drops valid mid-packet while req3 waits
    @(posedge clk); #2;
    load(1, 8'h91, 3, 1'b1);
    push_exp(1, 8'h91, 1);
    present();
    wait_writes("t6_pre", 1, 20);
    @(posedge clk); #2;
    drop_mask[1] = 1'b1;
    load(3, 8'hD1, 1, 1'b1);
    push_exp(3, 8'hD1, 1);
    present();
    @(negedge clk);
    check("t6_drop_wr_en", bus.fifo_wr_en, 1'b0);
    check("t6_drop_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("t6_released_busy", bus.busy, 1'b0);
    wait_writes("t6_req3", 1, 20);
    check("t6_req3_grant", bus.grant_id, 2'd3);
    @(posedge clk); #2;
    drop_mask[1] = 1'b0;
    push_exp(1, 8'h92, 2);
    present();
    drain("t6", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
